// File: rtl/instr_dispatch_coordinator_pkg.sv
// instr_dispatch_coordinator_pkg: instruction types, opcode decode and unit selectors for the dispatch coordinator
package instr_dispatch_coordinator_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] length;
        logic [15:0] acc_addr;
        logic [23:0] buffer_addr;
    } instr_type;

    typedef struct packed {
        logic [31:0] length;
        logic [23:0] buffer_addr;
    } weight_instr_type;

    localparam instr_type        INSTR_INIT  = '0;
    localparam weight_instr_type WEIGHT_INIT = '0;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_SYNC        = 8'hFF;
    localparam logic [7:0] OP_WEIGHT      = 8'h08;
    localparam logic [7:0] OP_WEIGHT_MASK = 8'hF8;
    localparam logic [7:0] OP_MATRIX      = 8'h20;
    localparam logic [7:0] OP_MATRIX_MASK = 8'hE0;
    localparam logic [7:0] OP_ACT         = 8'h80;
    localparam logic [7:0] OP_ACT_MASK    = 8'h80;

    typedef enum logic [1:0] {UNIT_W, UNIT_M, UNIT_A, UNIT_NONE} unit_sel_t;
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PULSE} sync_state_t;

    function automatic unit_sel_t unit_of(input logic [7:0] op);
        return ((op & OP_WEIGHT_MASK) == OP_WEIGHT) ? UNIT_W :
               ((op & OP_MATRIX_MASK) == OP_MATRIX) ? UNIT_M :
               ((op & OP_ACT_MASK) == OP_ACT && op != OP_SYNC) ? UNIT_A : UNIT_NONE;
    endfunction

    function automatic weight_instr_type to_weight_instr(input instr_type i);
        return '{length: i.length, buffer_addr: i.buffer_addr};
    endfunction

endpackage

// File: rtl/instr_dispatch_coordinator_fifo.sv
// coord_fifo: synchronous FIFO holding one unit's pending instructions
module coord_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [AW:0] cnt;

    assign head  = mem[rd];
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/instr_dispatch_coordinator.sv
// instr_dispatch_coordinator: queues decoded instructions per unit and dispatches them in tag-ordered fashion
module instr_dispatch_coordinator
    import instr_dispatch_coordinator_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int SEQ_WIDTH   = 8,
    parameter bit ORDERED     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  instr_type        instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic             busy,
    input  logic             weight_busy,
    input  logic             matrix_busy,
    input  logic             activation_busy,
    output weight_instr_type weight_instr,
    output logic             weight_instr_enable,
    output instr_type        matrix_instr,
    output logic             matrix_instr_enable,
    output instr_type        activation_instr,
    output logic             activation_instr_enable,
    output logic             synchronize,
    output logic             illegal_opcode
);
    typedef struct packed {
        instr_type              instr;
        logic [SEQ_WIDTH-1:0]   tag;
    } coord_entry_t;

    sync_state_t state, state_nx;
    unit_sel_t unit;
    weight_instr_type w_head;
    coord_entry_t m_head, a_head;
    logic w_full, w_empty, m_full, m_empty, a_full, a_empty;
    logic is_sync, is_nop, is_ill, ready_c, take, drain_ok, idle_q;
    logic push_w, push_m, push_a, go_w, go_m, go_a;
    logic [SEQ_WIDTH-1:0] acc_w, acc_m, dis_w, dis_m, m_gap, a_gap;

    assign unit    = unit_of(instr.opcode);
    assign is_sync = instr.opcode == OP_SYNC;
    assign is_nop  = instr.opcode == OP_NOP;
    assign is_ill  = unit == UNIT_NONE && !is_sync && !is_nop;

    assign drain_ok = w_empty && m_empty && a_empty && idle_q
                   && !(weight_busy || matrix_busy || activation_busy)
                   && !(weight_instr_enable || matrix_instr_enable || activation_instr_enable);
    assign ready_c = unit == UNIT_W ? !w_full :
                     unit == UNIT_M ? !m_full :
                     unit == UNIT_A ? !a_full :
                     is_sync ? drain_ok : 1'b1;
    assign instr_ready = rst && ready_c;
    assign take   = enable && instr_valid && instr_ready;
    assign push_w = take && unit == UNIT_W;
    assign push_m = take && unit == UNIT_M;
    assign push_a = take && unit == UNIT_A;

    // A negative gap (msb set) means the upstream unit has not yet dispatched what this entry depends on
    assign m_gap = dis_w - m_head.tag;
    assign a_gap = dis_m - a_head.tag;
    assign go_w = enable && !w_empty && !weight_busy && !weight_instr_enable;
    assign go_m = enable && !m_empty && !matrix_busy && !matrix_instr_enable && (!ORDERED || !m_gap[SEQ_WIDTH-1]);
    assign go_a = enable && !a_empty && !activation_busy && !activation_instr_enable && (!ORDERED || !a_gap[SEQ_WIDTH-1]);

    assign synchronize = state == S_PULSE;
    assign busy = !w_empty || !m_empty || !a_empty || state == S_DRAIN
               || weight_instr_enable || matrix_instr_enable || activation_instr_enable;

    coord_fifo #(.W($bits(weight_instr_type)), .DEPTH(QUEUE_DEPTH)) u_wq (
        .clk(clk), .rst(rst), .push(push_w), .pop(go_w), .din(to_weight_instr(instr)),
        .head(w_head), .full(w_full), .empty(w_empty));
    coord_fifo #(.W($bits(coord_entry_t)), .DEPTH(QUEUE_DEPTH)) u_mq (
        .clk(clk), .rst(rst), .push(push_m), .pop(go_m), .din({instr, acc_w}),
        .head(m_head), .full(m_full), .empty(m_empty));
    coord_fifo #(.W($bits(coord_entry_t)), .DEPTH(QUEUE_DEPTH)) u_aq (
        .clk(clk), .rst(rst), .push(push_a), .pop(go_a), .din({instr, acc_m}),
        .head(a_head), .full(a_full), .empty(a_empty));

    always_comb begin
        state_nx = (enable && instr_valid && is_sync) ? (instr_ready ? S_PULSE : S_DRAIN) :
                   (enable || state == S_PULSE) ? S_RUN : state;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_RUN;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idle_q                  <= 1'b0;
            acc_w                   <= '0;
            acc_m                   <= '0;
            dis_w                   <= '0;
            dis_m                   <= '0;
            weight_instr_enable     <= 1'b0;
            matrix_instr_enable     <= 1'b0;
            activation_instr_enable <= 1'b0;
            illegal_opcode          <= 1'b0;
            weight_instr            <= WEIGHT_INIT;
            matrix_instr            <= INSTR_INIT;
            activation_instr        <= INSTR_INIT;
        end else begin
            idle_q                  <= !(weight_busy || matrix_busy || activation_busy);
            weight_instr_enable     <= go_w;
            matrix_instr_enable     <= go_m;
            activation_instr_enable <= go_a;
            illegal_opcode          <= take && is_ill;
            if (go_w) weight_instr <= w_head;
            if (go_m) matrix_instr <= m_head.instr;
            if (go_a) activation_instr <= a_head.instr;
            if (push_w) acc_w <= acc_w + 1'b1;
            if (push_m) acc_m <= acc_m + 1'b1;
            if (go_w) dis_w <= dis_w + 1'b1;
            if (go_m) dis_m <= dis_m + 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_dispatch_coordinator.sv
// tb_instr_dispatch_coordinator: directed self-checking bench for the dispatch coordinator
module tb_instr_dispatch_coordinator;
    import instr_dispatch_coordinator_pkg::*;

    logic clk, rst, enable, instr_valid, instr_ready, busy;
    logic weight_busy, matrix_busy, activation_busy;
    logic weight_instr_enable, matrix_instr_enable, activation_instr_enable;
    logic synchronize, illegal_opcode;
    instr_type instr, matrix_instr, activation_instr;
    weight_instr_type weight_instr;
    int errors = 0;
    int checks = 0;

    instr_dispatch_coordinator dut (
        .clk(clk), .rst(rst), .enable(enable), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .busy(busy), .weight_busy(weight_busy),
        .matrix_busy(matrix_busy), .activation_busy(activation_busy),
        .weight_instr(weight_instr), .weight_instr_enable(weight_instr_enable),
        .matrix_instr(matrix_instr), .matrix_instr_enable(matrix_instr_enable),
        .activation_instr(activation_instr), .activation_instr_enable(activation_instr_enable),
        .synchronize(synchronize), .illegal_opcode(illegal_opcode));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic instr_type mk(input logic [7:0] op, input logic [31:0] len);
        return '{opcode: op, length: len, acc_addr: 16'h0A30, buffer_addr: {8'h00, len[15:0]}};
    endfunction

    initial begin
        rst = 1'b0; enable = 1'b1; instr_valid = 1'b0; instr = mk(8'h00, 32'h0);
        weight_busy = 1'b0; matrix_busy = 1'b0; activation_busy = 1'b0;
        tick(); tick();
        // reset state, with a valid WEIGHT already presented
        instr = mk(8'h08, 32'h500); instr_valid = 1'b1; #1;
        chk("rst_ready", instr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wen", weight_instr_enable, 0);
        chk("rst_men", matrix_instr_enable, 0);
        chk("rst_aen", activation_instr_enable, 0);
        chk("rst_sync", synchronize, 0);
        chk("rst_ill", illegal_opcode, 0);
        chk("rst_winstr", weight_instr, 0);
        chk("rst_minstr", matrix_instr, 0);
        // single WEIGHT, idle unit
        rst = 1'b1; #1;
        chk("w1_ready", instr_ready, 1);
        tick(); instr_valid = 1'b0;
        chk("w1_lat_wen", weight_instr_enable, 0);
        chk("w1_lat_busy", busy, 1);
        tick();
        chk("w1_wen", weight_instr_enable, 1);
        chk("w1_len", weight_instr.length, 32'h500);
        chk("w1_buf", weight_instr.buffer_addr, 24'h000500);
        tick();
        chk("w1_pulse_end", weight_instr_enable, 0);
        chk("w1_idle", busy, 0);
        // fill the weight queue while the unit is busy
        weight_busy = 1'b1; instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = mk(8'h08, 32'h100 + i); #1;
            chk("fill_ready", instr_ready, 1);
            tick();
        end
        instr = mk(8'h09, 32'h104); #1;
        chk("full_ready", instr_ready, 0);
        tick();
        chk("full_ready_hold", instr_ready, 0);
        chk("full_wen", weight_instr_enable, 0);
        chk("full_busy", busy, 1);
        instr_valid = 1'b0; weight_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain_wen", weight_instr_enable, 1);
            chk("drain_order", weight_instr.length, 32'h100 + k);
            tick();
            chk("drain_gap", weight_instr_enable, 0);
        end
        chk("drain_idle", busy, 0);
        tick();
        chk("fifth_dropped", weight_instr_enable, 0);
        // cross-unit ordering: weight -> matrix -> activation
        weight_busy = 1'b1; instr_valid = 1'b1;
        instr = mk(8'h08, 32'h200); tick();
        instr = mk(8'h20, 32'h300); tick();
        instr = mk(8'h80, 32'h400); tick();
        instr_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("ord_hold_m", matrix_instr_enable, 0);
            chk("ord_hold_a", activation_instr_enable, 0);
            tick();
        end
        weight_busy = 1'b0;
        tick();
        chk("ord_w_en", weight_instr_enable, 1);
        chk("ord_w_len", weight_instr.length, 32'h200);
        chk("ord_w_m", matrix_instr_enable, 0);
        chk("ord_w_a", activation_instr_enable, 0);
        tick();
        chk("ord_m_w", weight_instr_enable, 0);
        chk("ord_m_en", matrix_instr_enable, 1);
        chk("ord_m_len", matrix_instr.length, 32'h300);
        chk("ord_m_a", activation_instr_enable, 0);
        tick();
        chk("ord_a_m", matrix_instr_enable, 0);
        chk("ord_a_en", activation_instr_enable, 1);
        chk("ord_a_len", activation_instr.length, 32'h400);
        tick();
        chk("ord_a_end", activation_instr_enable, 0);
        chk("ord_idle", busy, 0);
        // SYNC behind a queued MATRIX with matrix_busy high for 3 cycles
        matrix_busy = 1'b1; instr = mk(8'h21, 32'h600); instr_valid = 1'b1; #1;
        chk("sync_m_ready", instr_ready, 1);
        tick();
        instr = mk(8'hFF, 32'h0); #1;
        chk("sync_wait_ready", instr_ready, 0);
        chk("sync_wait_busy", busy, 1);
        tick();
        chk("sync_wait_ready2", instr_ready, 0);
        chk("sync_wait_pulse", synchronize, 0);
        tick();
        matrix_busy = 1'b0; #1;
        chk("sync_busy_fell_ready", instr_ready, 0);
        tick();
        chk("sync_m_dispatch", matrix_instr_enable, 1);
        chk("sync_m_len", matrix_instr.length, 32'h600);
        chk("sync_guard_ready", instr_ready, 0);
        chk("sync_early", synchronize, 0);
        tick();
        chk("sync_drained_ready", instr_ready, 1);
        chk("sync_not_yet", synchronize, 0);
        tick(); instr_valid = 1'b0;
        chk("sync_pulse", synchronize, 1);
        tick();
        chk("sync_pulse_end", synchronize, 0);
        chk("sync_idle", busy, 0);
        tick();
        chk("sync_once", synchronize, 0);
        // illegal opcodes and NOP
        instr = mk(8'h44, 32'h0); instr_valid = 1'b1; #1;
        chk("ill_ready", instr_ready, 1);
        tick(); instr_valid = 1'b0;
        chk("ill_pulse", illegal_opcode, 1);
        chk("ill_busy", busy, 0);
        tick();
        chk("ill_pulse_end", illegal_opcode, 0);
        instr = mk(8'h00, 32'h0); instr_valid = 1'b1; #1;
        chk("nop_ready", instr_ready, 1);
        tick(); instr_valid = 1'b0;
        chk("nop_no_ill", illegal_opcode, 0);
        chk("nop_busy", busy, 0);
        chk("nop_no_wen", weight_instr_enable, 0);
        instr = mk(8'h40, 32'h0); instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        chk("ill40_pulse", illegal_opcode, 1);
        // reset mid-operation flushes queues and counters
        weight_busy = 1'b1; instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = mk(8'h08, 32'h700 + i);
            tick();
        end
        instr_valid = 1'b0;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wen", weight_instr_enable, 0);
        chk("mid_rst_winstr", weight_instr, 0);
        instr = mk(8'h08, 32'h0); instr_valid = 1'b1; #1;
        chk("mid_rst_ready", instr_ready, 0);
        instr_valid = 1'b0; rst = 1'b1; weight_busy = 1'b0;
        tick();
        chk("flushed_wen", weight_instr_enable, 0);
        tick();
        chk("flushed_wen2", weight_instr_enable, 0);
        chk("flushed_busy", busy, 0);
        instr = mk(8'h22, 32'h800); instr_valid = 1'b1; #1;
        chk("post_rst_m_ready", instr_ready, 1);
        tick(); instr_valid = 1'b0;
        chk("post_rst_m_lat", matrix_instr_enable, 0);
        tick();
        chk("post_rst_m_en", matrix_instr_enable, 1);
        chk("post_rst_m_len", matrix_instr.length, 32'h800);
        instr = mk(8'h0F, 32'h900); instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        tick();
        chk("post_rst_w_en", weight_instr_enable, 1);
        chk("post_rst_w_len", weight_instr.length, 32'h900);
        // global enable low holds everything
        tick();
        enable = 1'b0; instr = mk(8'h08, 32'hA00); instr_valid = 1'b1;
        tick(); tick();
        chk("en_low_wen", weight_instr_enable, 0);
        chk("en_low_busy", busy, 0);
        enable = 1'b1;
        tick(); instr_valid = 1'b0;
        chk("en_resume_lat", weight_instr_enable, 0);
        tick();
        chk("en_resume_wen", weight_instr_enable, 1);
        chk("en_resume_len", weight_instr.length, 32'hA00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
